fir_mac_scheduler: RTL and testbench

//  Sequencer for the single-MAC, RAM-backed decimating FIR datapath, shared across NUM_CH audio channels.

---
 rtl/fir_sched_pkg.sv | 26 ++
 rtl/fir_mac_scheduler_if.sv | 49 ++++
 rtl/fir_tap_counter.sv | 63 ++++++
 rtl/fir_mac_scheduler.sv | 176 +++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_sched_pkg.sv
// ---------------------------------------------------------------------------
// fir_sched_pkg
// Shared definitions for the FIR MAC scheduler: the sequencer state type,
// the length of the pipeline drain phase, and a helper that folds an address
// back into the sample ring.
// ---------------------------------------------------------------------------
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    // Cycles spent after the last read so the RAM/ROM and strobe delay empty
    localparam int FLUSH_CYCLES = 2;

    // Wrap an address into a ring of depth 2**addrWidth (addrWidth <= 16)
    function automatic logic [15:0] ringWrap(input logic [15:0] value,
                                             input int unsigned addrWidth);
        logic [15:0] mask;
        mask = 16'((32'd1 << addrWidth) - 32'd1);
        return value & mask;
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// ---------------------------------------------------------------------------
// fir_mac_scheduler_if
// Bundles the sample-stream input and every sequencer output of the FIR MAC
// scheduler.
//   master : the scheduler (samples in_valid, drives everything else)
//   slave  : the surrounding datapath / sample source
// Signals:
//   in_valid  new sample for all channels this cycle
//   wr_en     sample RAM write strobe
//   wr_addr   ring write pointer
//   rd_addr   sample RAM read address
//   coef_addr coefficient ROM address
//   ch_sel    channel of the current read / MAC op
//   mac_clr   load product instead of accumulate
//   mac_en    MAC operand valid
//   dump      accumulator of dump_ch complete (1 cycle)
//   dump_ch   channel being dumped
//   busy      block in progress
//   overrun   sticky: trigger arrived while busy
// ---------------------------------------------------------------------------
interface fir_mac_scheduler_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int COEF_WIDTH = 8
);
    logic                  in_valid;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [COEF_WIDTH-1:0] coef_addr;
    logic [1:0]            ch_sel;
    logic                  mac_clr;
    logic                  mac_en;
    logic                  dump;
    logic [1:0]            dump_ch;
    logic                  busy;
    logic                  overrun;

    modport master (
        input  in_valid,
        output wr_en, wr_addr, rd_addr, coef_addr, ch_sel,
        output mac_clr, mac_en, dump, dump_ch, busy, overrun
    );

    modport slave (
        output in_valid,
        input  wr_en, wr_addr, rd_addr, coef_addr, ch_sel,
        input  mac_clr, mac_en, dump, dump_ch, busy, overrun
    );
endinterface

// File: rtl/fir_tap_counter.sv
// ---------------------------------------------------------------------------
// fir_tap_counter
// Tap index k (0..NUM_TAPS-1) nested inside channel index ch (0..NUM_CH-1).
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start_i      restart at k=0, ch=0
//   step_i       advance one tap (wraps into the next channel)
//   k_o, ch_o    current tap / channel
//   last_tap_o   k is the final tap of a channel
//   last_ch_o    ch is the final channel
// ---------------------------------------------------------------------------
module fir_tap_counter #(
    parameter int NUM_TAPS = 199,
    parameter int NUM_CH   = 2,
    parameter int K_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               step_i,
    output logic [K_WIDTH-1:0] k_o,
    output logic [1:0]         ch_o,
    output logic               last_tap_o,
    output logic               last_ch_o
);

    logic [K_WIDTH-1:0] k_q, k_d;
    logic [1:0]         ch_q, ch_d;

    assign k_o        = k_q;
    assign ch_o       = ch_q;
    assign last_tap_o = (k_q == K_WIDTH'(NUM_TAPS - 1));
    assign last_ch_o  = (ch_q == 2'(NUM_CH - 1));

    // Next tap: restart wins over step; the final tap rolls into the next channel
    always_comb begin
        k_d  = k_q;
        ch_d = ch_q;
        if (start_i) begin
            k_d  = '0;
            ch_d = '0;
        end else if (step_i) begin
            if (last_tap_o) begin
                k_d  = '0;
                ch_d = last_ch_o ? 2'd0 : ch_q + 2'd1;
            end else begin
                k_d = k_q + K_WIDTH'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q  <= '0;
            ch_q <= '0;
        end else begin
            k_q  <= k_d;
            ch_q <= ch_d;
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// ---------------------------------------------------------------------------
// fir_mac_scheduler
// Sequencer for a single-MAC, RAM-backed decimating FIR shared by NUM_CH
// channels. Owns the ring write pointer and decimation counter; every RATE
// samples it walks NUM_TAPS sample/coefficient reads per channel and emits
// the MAC clear/enable/dump strobes one and two cycles behind the addresses.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    fir_mac_scheduler_if.master (in_valid in; addresses, strobes,
//          busy and overrun out)
// Build option:
//   COEF_SYMMETRIC_EN  fold coef_addr for a half-depth linear-phase ROM
// ---------------------------------------------------------------------------
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int RATE       = 8,
    parameter int NUM_TAPS   = 199,
    parameter int ADDR_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int NUM_CH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_mac_scheduler_if.master  bus
);

    localparam int DECI_W = (RATE > 1) ? $clog2(RATE) : 1;

    sched_state_t          state_q;
    logic [1:0]            flush_cnt_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DECI_W-1:0]     deci_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [COEF_WIDTH-1:0] coef_addr_q;
    logic                  mac_en_q;
    logic                  mac_clr_q;
    logic                  last_seen_q;
    logic [1:0]            last_ch_sel_q;
    logic                  dump_q;
    logic [1:0]            dump_ch_q;
    logic                  busy_q;
    logic                  overrun_q;

    logic                  trigger;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_d;
    logic [ADDR_WIDTH-1:0] k;
    logic [ADDR_WIDTH-1:0] kNext;
    logic [1:0]            ch;
    logic                  lastTap;
    logic                  lastCh;

    // Coefficient address for tap k; the symmetric build mirrors the upper half
    function automatic logic [COEF_WIDTH-1:0] coefOf(input logic [ADDR_WIDTH-1:0] tap);
`ifdef COEF_SYMMETRIC_EN
        if (int'(tap) < (NUM_TAPS + 1) / 2)
            return COEF_WIDTH'(tap);
        else
            return COEF_WIDTH'(NUM_TAPS - 1 - int'(tap));
`else
        return COEF_WIDTH'(tap);
`endif
    endfunction

    fir_tap_counter #(
        .NUM_TAPS (NUM_TAPS),
        .NUM_CH   (NUM_CH),
        .K_WIDTH  (ADDR_WIDTH)
    ) u_tap_counter (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .step_i     (state_q == RUN),
        .k_o        (k),
        .ch_o       (ch),
        .last_tap_o (lastTap),
        .last_ch_o  (lastCh)
    );

    // Trigger fires on the sample that completes a decimation period; the
    // window it opens ends on that very sample, so base sits NUM_TAPS-1 back
    always_comb begin
        trigger = bus.in_valid && (deci_q == DECI_W'(RATE - 1));
        start   = trigger && (state_q == IDLE);
        base_d  = ADDR_WIDTH'(ringWrap(16'(wr_addr_q) - 16'(NUM_TAPS - 1), ADDR_WIDTH));
        kNext   = lastTap ? '0 : k + ADDR_WIDTH'(1);
    end

    // Sequencer: write side, decimation, read addresses and delayed strobes.
    // Addresses are loaded one tap ahead so rd_addr/coef_addr always match the
    // counter's current k; mac_en/mac_clr trail them by the 1-cycle RAM/ROM
    // latency and dump trails the channel's last mac_en by one more cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            flush_cnt_q   <= '0;
            wr_addr_q     <= '0;
            deci_q        <= '0;
            base_q        <= '0;
            rd_addr_q     <= '0;
            coef_addr_q   <= '0;
            mac_en_q      <= 1'b0;
            mac_clr_q     <= 1'b0;
            last_seen_q   <= 1'b0;
            last_ch_sel_q <= '0;
            dump_q        <= 1'b0;
            dump_ch_q     <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                wr_addr_q <= ADDR_WIDTH'(ringWrap(16'(wr_addr_q) + 16'd1, ADDR_WIDTH));
                deci_q    <= (deci_q == DECI_W'(RATE - 1)) ? '0 : deci_q + DECI_W'(1);
            end

            mac_en_q      <= (state_q == RUN);
            mac_clr_q     <= (state_q == RUN) && (k == '0);
            last_seen_q   <= (state_q == RUN) && lastTap;
            last_ch_sel_q <= ch;
            dump_q        <= last_seen_q;
            if (last_seen_q)
                dump_ch_q <= last_ch_sel_q;

            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q     <= RUN;
                        base_q      <= base_d;
                        rd_addr_q   <= base_d;
                        coef_addr_q <= coefOf('0);
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (trigger)
                        overrun_q <= 1'b1;
                    if (lastTap && lastCh) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= '0;
                    end else begin
                        rd_addr_q   <= lastTap ? base_q
                                     : ADDR_WIDTH'(ringWrap(16'(rd_addr_q) + 16'd1, ADDR_WIDTH));
                        coef_addr_q <= coefOf(kNext);
                    end
                end
                FLUSH: begin
                    if (trigger)
                        overrun_q <= 1'b1;
                    if (flush_cnt_q == 2'(FLUSH_CYCLES - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_en     = bus.in_valid;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.coef_addr = coef_addr_q;
    assign bus.ch_sel    = ch;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.dump      = dump_q;
    assign bus.dump_ch   = dump_ch_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_scheduler
// Two schedulers (NUM_CH=2 and NUM_CH=1, RATE=4, NUM_TAPS=5, ADDR_WIDTH=3)
// share clock, reset and in_valid. A cycle-based model predicts, for each
// cycle after an accepted trigger, the read window, strobes, busy and
// overrun; a hand-written table pins down the first block's read addresses.
// ---------------------------------------------------------------------------
module tb_fir_mac_scheduler;

    localparam int RATE = 4;
    localparam int TAPS = 5;
    localparam int AW   = 3;

    logic clk;
    logic reset;

    fir_mac_scheduler_if #(.ADDR_WIDTH(AW), .COEF_WIDTH(AW)) bus2 ();
    fir_mac_scheduler_if #(.ADDR_WIDTH(AW), .COEF_WIDTH(AW)) bus1 ();

    fir_mac_scheduler #(
        .RATE(RATE), .NUM_TAPS(TAPS), .ADDR_WIDTH(AW), .COEF_WIDTH(AW), .NUM_CH(2)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    fir_mac_scheduler #(
        .RATE(RATE), .NUM_TAPS(TAPS), .ADDR_WIDTH(AW), .COEF_WIDTH(AW), .NUM_CH(1)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int assertCount = 0;
    int failCount   = 0;

    int   cyc;
    int   wrM;
    int   deciM;
    int   nch[2]     = '{2, 1};
    int   trigCyc[2];
    int   baseM[2];
    bit   ovM[2];
    logic curIv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int expCoef(input int k);
`ifdef COEF_SYMMETRIC_EN
        return (k < (TAPS + 1) / 2) ? k : TAPS - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic bit modelBusy(input int d);
        int rel;
        rel = cyc - trigCyc[d];
        return (rel >= 1) && (rel <= nch[d] * TAPS + 2);
    endfunction

    task automatic modelReset();
        wrM   = 0;
        deciM = 0;
        for (int d = 0; d < 2; d++) begin
            trigCyc[d] = -1000;
            baseM[d]   = 0;
            ovM[d]     = 1'b0;
        end
    endtask

    // Advance the model by the inputs applied in the current cycle
    task automatic modelUpdate(input logic iv, input logic rst);
        if (rst) begin
            modelReset();
        end else if (iv) begin
            if (deciM == RATE - 1) begin
                for (int d = 0; d < 2; d++) begin
                    if (modelBusy(d)) begin
                        ovM[d] = 1'b1;
                    end else begin
                        trigCyc[d] = cyc;
                        baseM[d]   = (wrM - (TAPS - 1) + 8) % 8;
                    end
                end
            end
            wrM   = (wrM + 1) % 8;
            deciM = (deciM + 1) % RATE;
        end
    endtask

    task automatic checkDut(input int d, input string pfx,
                            input logic [2:0] wrA, input logic wrE,
                            input logic [2:0] rdA, input logic [2:0] coefA,
                            input logic [1:0] chSel, input logic macEn, input logic macClr,
                            input logic dmp, input logic [1:0] dmpCh,
                            input logic bsy, input logic ovr);
        int  rel, n, idx;
        bit  enExp, clrExp, dumpExp;
        rel = cyc - trigCyc[d];
        n   = nch[d] * TAPS;
        checkOutput($sformatf("%s wr_addr c%0d", pfx, cyc), 32'(wrA), 32'(wrM));
        checkOutput($sformatf("%s wr_en c%0d", pfx, cyc), 32'(wrE), 32'(curIv));
        checkOutput($sformatf("%s busy rel%0d", pfx, rel), 32'(bsy), 32'(modelBusy(d)));
        checkOutput($sformatf("%s overrun c%0d", pfx, cyc), 32'(ovr), 32'(ovM[d]));
        if (rel >= 1 && rel <= n) begin
            idx = rel - 1;
            checkOutput($sformatf("%s rd_addr rel%0d", pfx, rel), 32'(rdA),
                        32'((baseM[d] + idx % TAPS) % 8));
            checkOutput($sformatf("%s coef_addr rel%0d", pfx, rel), 32'(coefA),
                        32'(expCoef(idx % TAPS)));
            checkOutput($sformatf("%s ch_sel rel%0d", pfx, rel), 32'(chSel), 32'(idx / TAPS));
        end
        enExp   = (rel >= 2) && (rel <= n + 1);
        clrExp  = enExp && ((rel - 2) % TAPS == 0);
        dumpExp = (rel >= TAPS + 2) && (rel <= n + 2) && ((rel - 2) % TAPS == 0);
        checkOutput($sformatf("%s mac_en rel%0d", pfx, rel), 32'(macEn), 32'(enExp));
        checkOutput($sformatf("%s mac_clr rel%0d", pfx, rel), 32'(macClr), 32'(clrExp));
        checkOutput($sformatf("%s dump rel%0d", pfx, rel), 32'(dmp), 32'(dumpExp));
        if (dumpExp)
            checkOutput($sformatf("%s dump_ch rel%0d", pfx, rel), 32'(dmpCh),
                        32'((rel - 2) / TAPS - 1));
    endtask

    // One clock cycle: drive inputs, check both DUTs, update model, clock
    task automatic applyStimulus(input logic iv, input logic rst);
        bus2.in_valid = iv;
        bus1.in_valid = iv;
        reset         = rst;
        curIv         = iv;
        #1;
        checkDut(0, "ch2", bus2.wr_addr, bus2.wr_en, bus2.rd_addr, bus2.coef_addr,
                 bus2.ch_sel, bus2.mac_en, bus2.mac_clr, bus2.dump, bus2.dump_ch,
                 bus2.busy, bus2.overrun);
        checkDut(1, "ch1", bus1.wr_addr, bus1.wr_en, bus1.rd_addr, bus1.coef_addr,
                 bus1.ch_sel, bus1.mac_en, bus1.mac_clr, bus1.dump, bus1.dump_ch,
                 bus1.busy, bus1.overrun);
        modelUpdate(iv, rst);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " ch2 wr_addr"},   32'(bus2.wr_addr),   0);
        checkOutput({tag, " ch2 rd_addr"},   32'(bus2.rd_addr),   0);
        checkOutput({tag, " ch2 coef_addr"}, 32'(bus2.coef_addr), 0);
        checkOutput({tag, " ch2 ch_sel"},    32'(bus2.ch_sel),    0);
        checkOutput({tag, " ch2 mac_clr"},   32'(bus2.mac_clr),   0);
        checkOutput({tag, " ch2 mac_en"},    32'(bus2.mac_en),    0);
        checkOutput({tag, " ch2 dump"},      32'(bus2.dump),      0);
        checkOutput({tag, " ch2 dump_ch"},   32'(bus2.dump_ch),   0);
        checkOutput({tag, " ch2 busy"},      32'(bus2.busy),      0);
        checkOutput({tag, " ch2 overrun"},   32'(bus2.overrun),   0);
        checkOutput({tag, " ch1 rd_addr"},   32'(bus1.rd_addr),   0);
        checkOutput({tag, " ch1 mac_en"},    32'(bus1.mac_en),    0);
        checkOutput({tag, " ch1 busy"},      32'(bus1.busy),      0);
        checkOutput({tag, " ch1 overrun"},   32'(bus1.overrun),   0);
    endtask

    initial begin
        int rdTable[10];
        rdTable = '{7, 0, 1, 2, 3, 7, 0, 1, 2, 3};

        reset         = 1'b1;
        bus2.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        curIv         = 1'b0;
        cyc           = 0;
        modelReset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkResetValues("reset");

        // Test 1: four back-to-back samples; trigger sample lands at address 3
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t1 rd_addr step%0d", i), 32'(bus2.rd_addr), 32'(rdTable[i]));
            applyStimulus(1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);

        // Test 2: one sample every 4 cycles, 32 samples, pointer wraps repeatedly
        for (int s = 0; s < 32; s++) begin
            applyStimulus(1'b1, 1'b0);
            for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0);
        end
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("t2 overrun", 32'(bus2.overrun), 0);

        // Test 3: eight back-to-back samples, second trigger lands mid-block
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("t3 overrun sticky", 32'(bus2.overrun), 1);

        // Test 4: reset during the third RUN cycle
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkResetValues("midrun");
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
